checksum_feeder: RTL and testbench

Upstream DMA-style feeder for the Avalon-MM checksum accumulator. The HPS loads 64-bit words into a local FIFO through a CSR slave port, programs a length and starts a job. The block then drives the accumulator's slave port as a master: one arm write carrying the word count, followed by the data words. It waits for the accumulator's completion interrupt, reads back the 32-bit sum, latches it in a result register and raises its own interrupt to the host.

---
 rtl/checksum_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_checksum_feeder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checksum_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// checksum_feeder: CSR-loaded FIFO that arms the checksum accumulator, streams
// the queued words into it and captures the returned sum. Optional watchdog:
// define CHECKSUM_FEEDER_TIMEOUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module checksum_feeder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  s_address,
    input  logic        s_write,
    input  logic [63:0] s_writedata,
    input  logic        s_read,
    output logic [63:0] s_readdata,
    output logic        irq,
    output logic [9:0]  m_address,
    output logic        m_write,
    output logic [63:0] m_writedata,
    output logic        m_read,
    input  logic [63:0] m_readdata,
    input  logic        m_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_IRQ = 3'd3,
        S_READ     = 3'd4,
        S_CAPTURE  = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [63:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic [15:0]    r_len;
    logic [15:0]    r_remain;
    logic [31:0]    r_result;
    logic           r_done;
    logic           r_ovf;
    logic           r_tmo;
    logic           r_irq;
    logic [63:0]    r_rdata;
    logic [63:0]    w_status;

    logic w_wr_data, w_wr_ctrl, w_start, w_clr, w_abort, w_go;
    logic w_empty, w_full, w_push, w_pop, w_drop, w_capture, w_timeout;

    assign w_wr_data = s_write && (s_address == 3'd0);
    assign w_wr_ctrl = s_write && (s_address == 3'd1);
    assign w_start   = w_wr_ctrl && s_writedata[0];
    assign w_clr     = w_wr_ctrl && s_writedata[1];
    assign w_abort   = w_wr_ctrl && s_writedata[2];
    assign w_go      = w_start && !w_abort && (r_state == S_IDLE);

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_pop     = (r_state == S_SEND) && !w_empty;
    // A DATA write can never coincide with ABORT: both come through the one CSR port.
    assign w_push    = w_wr_data && (!w_full || w_pop);
    assign w_drop    = w_wr_data && !w_push;
    assign w_capture = (r_state == S_READ) && !w_abort;

`ifdef CHECKSUM_FEEDER_TIMEOUT_EN
    logic [9:0] r_wdog;
    logic       w_wdog_run;
    assign w_wdog_run = (r_state == S_WAIT_IRQ) || ((r_state == S_SEND) && w_empty);
    assign w_timeout  = w_wdog_run && (r_wdog == 10'h3FF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (!w_wdog_run) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 10'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        m_write     = 1'b0;
        m_address   = '0;
        m_writedata = '0;
        m_read      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                m_write     = 1'b1;
                m_address   = 10'h200;
                m_writedata = {48'h0, r_len};
                w_state_nxt = (r_len != 16'd0) ? S_SEND : S_WAIT_IRQ;
            end
            S_SEND: begin
                if (w_pop) begin
                    m_write     = 1'b1;
                    m_writedata = r_mem[r_rd_ptr];
                    if (r_remain == 16'd1) w_state_nxt = S_WAIT_IRQ;
                end
            end
            S_WAIT_IRQ: begin
                if (m_irq) w_state_nxt = S_READ;
            end
            S_READ: begin
                m_read      = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_timeout || w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        end
    end

    // The accumulator returns its sum combinationally, so readdata is sampled in the m_read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_remain <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_tmo    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (s_write && (s_address == 3'd2)) r_len <= s_writedata[15:0];
            if (r_state == S_ARM) r_remain <= r_len;
            else if (w_pop)       r_remain <= r_remain - 16'd1;
            if (w_capture) r_result <= m_readdata[31:0];
            if (w_capture)          r_done <= 1'b1;
            else if (w_clr || w_go) r_done <= 1'b0;
            if (w_capture || w_timeout) r_irq <= 1'b1;
            else if (w_clr || w_go)     r_irq <= 1'b0;
            if (w_drop)     r_ovf <= 1'b1;
            else if (w_clr) r_ovf <= 1'b0;
            if (w_timeout)  r_tmo <= 1'b1;
            else if (w_clr) r_tmo <= 1'b0;
        end
    end

    always_comb begin
        w_status         = '0;
        w_status[0]      = (r_state != S_IDLE);
        w_status[1]      = r_done;
        w_status[2]      = r_ovf;
        w_status[3]      = r_tmo;
        w_status[8 +: LW] = r_level;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (s_read) begin
            case (s_address)
                3'd2:    r_rdata <= {48'h0, r_len};
                3'd3:    r_rdata <= w_status;
                3'd4:    r_rdata <= {32'h0, r_result};
                default: r_rdata <= '0;
            endcase
        end
    end

    assign s_readdata = r_rdata;
    assign irq        = r_irq;

    logic w_unused;
    assign w_unused = &{1'b0, s_writedata[63:16], m_readdata[63:32]};

endmodule
`default_nettype wire

// File: tb/tb_checksum_feeder.sv
`timescale 1ns/1ps
// tb_checksum_feeder: drives jobs through the CSR port against a simple accumulator
// model and a queue-based reference of the FIFO contents and expected sums.
module tb_checksum_feeder;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  s_address;
    logic        s_write;
    logic [63:0] s_writedata;
    logic        s_read;
    logic [63:0] s_readdata;
    logic        irq;
    logic [9:0]  m_address;
    logic        m_write;
    logic [63:0] m_writedata;
    logic        m_read;
    logic [63:0] m_readdata;
    logic        m_irq;

    checksum_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
        .s_read(s_read), .s_readdata(s_readdata), .irq(irq),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_read(m_read), .m_readdata(m_readdata), .m_irq(m_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [63:0] ref_q[$];
    logic        e_done, e_ovf, e_tmo;
    logic [31:0] last_result;

    // Accumulator model: irq two cycles after the last data word, one after an empty arm
    logic        acc_mute;
    logic [31:0] acc_sum;
    logic [15:0] acc_cnt;
    logic        acc_pend;
    assign m_readdata = {32'h0, acc_sum};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_irq    <= 1'b0;
            acc_sum  <= '0;
            acc_cnt  <= '0;
            acc_pend <= 1'b0;
        end else begin
            m_irq    <= acc_pend && !acc_mute;
            acc_pend <= 1'b0;
            if (m_write && m_address == 10'h200) begin
                acc_sum <= '0;
                acc_cnt <= m_writedata[15:0];
                if (m_writedata[15:0] == 16'd0) m_irq <= !acc_mute;
            end else if (m_write && m_address == 10'h000) begin
                acc_sum <= acc_sum + m_writedata[31:0] + m_writedata[63:32];
                acc_cnt <= acc_cnt - 16'd1;
                if (acc_cnt == 16'd1) acc_pend <= 1'b1;
            end
        end
    end

    // Bus monitor
    logic [63:0] wr_q[$];
    logic [63:0] arm_q[$];
    always @(posedge clk) begin
        if (!reset && m_write && m_address == 10'h000) wr_q.push_back(m_writedata);
        if (!reset && m_write && m_address == 10'h200) arm_q.push_back(m_writedata);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [63:0] d);
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [63:0] d);
        s_address = a; s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic push(input logic [63:0] w);
        csr_write(3'd0, w);
        if (ref_q.size() < DEPTH) ref_q.push_back(w);
        else e_ovf = 1'b1;
    endtask

    function automatic logic [63:0] exp_status(input logic busy);
        logic [63:0] v;
        v = '0;
        v[0] = busy; v[1] = e_done; v[2] = e_ovf; v[3] = e_tmo;
        v[8 +: LW] = LW'(ref_q.size());
        return v;
    endfunction

    task automatic start_job(input int len, input string tag);
        csr_write(3'd2, 64'(len));
        wr_q.delete();
        arm_q.delete();
        csr_write(3'd1, 64'h1);
        e_done = 1'b0;
        check({tag, " irq cleared by start"}, {63'h0, irq}, 64'h0);
    endtask

    task automatic wait_irq(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (irq) break;
            @(negedge clk);
        end
        check({tag, " irq raised"}, {63'h0, irq}, 64'h1);
    endtask

    task automatic finish_job(input int len, input string tag);
        logic [31:0] s;
        logic [63:0] w, rd;
        s = '0;
        wait_irq(300, tag);
        check({tag, " arm count"}, 64'(arm_q.size()), 64'h1);
        if (arm_q.size() > 0) check({tag, " arm data"}, arm_q[0], 64'(len));
        check({tag, " data count"}, 64'(wr_q.size()), 64'(len));
        for (int i = 0; i < len; i++) begin
            w = ref_q.pop_front();
            s = s + w[31:0] + w[63:32];
            if (i < wr_q.size()) check({tag, " data word"}, wr_q[i], w);
        end
        e_done = 1'b1;
        last_result = s;
        csr_read(3'd4, rd);
        check({tag, " result"}, rd, {32'h0, s});
        csr_read(3'd3, rd);
        check({tag, " status"}, rd, exp_status(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [63:0] rd;
        int n, extra, sent;
        reset = 1'b1; s_address = '0; s_write = 1'b0; s_writedata = '0; s_read = 1'b0;
        acc_mute = 1'b0; e_done = 1'b0; e_ovf = 1'b0; e_tmo = 1'b0; last_result = '0;
        repeat (3) @(negedge clk);
        check("reset irq", {63'h0, irq}, 64'h0);
        check("reset m_write", {63'h0, m_write}, 64'h0);
        check("reset m_writedata", m_writedata, 64'h0);
        check("reset s_readdata", s_readdata, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        csr_read(3'd3, rd);
        check("reset status", rd, 64'h0);
        csr_read(3'd4, rd);
        check("reset result", rd, 64'h0);

        // Directed job with exact bus timing
        push({32'h2, 32'h1}); push({32'h4, 32'h3}); push({32'h6, 32'h5});
        start_job(3, "t1");
        check("t1 arm write", {63'h0, m_write}, 64'h1);
        check("t1 arm address", {54'h0, m_address}, 64'h200);
        check("t1 arm data", m_writedata, 64'h3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1 data write", {63'h0, m_write}, 64'h1);
            check("t1 data address", {54'h0, m_address}, 64'h0);
            check("t1 data word", m_writedata, ref_q[i]);
        end
        @(negedge clk);
        check("t1 no early read", {63'h0, m_read}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        check("t1 read at d+3", {63'h0, m_read}, 64'h1);
        check("t1 irq low at d+3", {63'h0, irq}, 64'h0);
        @(negedge clk);
        check("t1 irq at d+4", {63'h0, irq}, 64'h1);
        finish_job(3, "t1");
        check("t1 sum 0x15", {32'h0, last_result}, 64'h15);

        // Zero-length job
        start_job(0, "t2");
        finish_job(0, "t2");

        // Overflow and CLR
        for (int i = 0; i < 17; i++) push({$urandom, $urandom});
        csr_read(3'd3, rd);
        check("t3 status full ovf", rd, exp_status(1'b0));
        csr_write(3'd1, 64'h2);
        e_ovf = 1'b0; e_done = 1'b0;
        csr_read(3'd3, rd);
        check("t3 status after clr", rd, exp_status(1'b0));
        check("t3 irq after clr", {63'h0, irq}, 64'h0);
        start_job(16, "t3");
        finish_job(16, "t3");

        // Stall on empty FIFO, then resume
        push({$urandom, $urandom}); push({$urandom, $urandom});
        start_job(4, "t4");
        repeat (10) @(negedge clk);
        check("t4 stalled writes", 64'(wr_q.size()), 64'h2);
        csr_read(3'd3, rd);
        check("t4 busy", {63'h0, rd[0]}, 64'h1);
        push({$urandom, $urandom}); push({$urandom, $urandom});
        finish_job(4, "t4");

        // Abort in SEND
        for (int i = 0; i < 5; i++) push({$urandom, $urandom});
        csr_write(3'd2, 64'h8);
        wr_q.delete(); arm_q.delete();
        csr_write(3'd1, 64'h1);
        e_done = 1'b0;
        @(negedge clk);
        csr_write(3'd1, 64'h4);
        ref_q.delete();
        check("t5 no write after abort", {63'h0, m_write}, 64'h0);
        sent = wr_q.size();
        check("t5 words before abort", 64'(sent), 64'h1);
        repeat (8) @(negedge clk);
        check("t5 writes frozen", 64'(wr_q.size()), 64'(sent));
        csr_read(3'd3, rd);
        check("t5 status idle empty", rd, exp_status(1'b0));
        csr_read(3'd4, rd);
        check("t5 result kept", rd, {32'h0, last_result});
        push({$urandom, $urandom});
        start_job(1, "t5b");
        finish_job(1, "t5b");

        // Withheld completion interrupt
        acc_mute = 1'b1;
        push({$urandom, $urandom});
        start_job(1, "t6");
`ifdef CHECKSUM_FEEDER_TIMEOUT_EN
        wait_irq(1200, "t6 timeout");
        void'(ref_q.pop_front());
        e_tmo = 1'b1;
        csr_read(3'd3, rd);
        check("t6 status tmo", rd, exp_status(1'b0));
        csr_read(3'd4, rd);
        check("t6 result kept", rd, {32'h0, last_result});
        push({$urandom, $urandom});
        start_job(1, "t6b");
        repeat (10) @(negedge clk);
`else
        repeat (60) @(negedge clk);
        check("t6 still waiting irq", {63'h0, irq}, 64'h0);
`endif
        csr_read(3'd3, rd);
        check("t6 busy tmo0", rd[3:0], {e_tmo, 3'b001});
        #2 reset = 1'b1;
        #1;
        check("t7 async irq", {63'h0, irq}, 64'h0);
        check("t7 async m_write", {63'h0, m_write}, 64'h0);
        check("t7 async m_read", {63'h0, m_read}, 64'h0);
        check("t7 async m_address", {54'h0, m_address}, 64'h0);
        check("t7 async s_readdata", s_readdata, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        acc_mute = 1'b0;
        ref_q.delete();
        e_done = 1'b0; e_ovf = 1'b0; e_tmo = 1'b0; last_result = '0;
        @(negedge clk);
        csr_read(3'd3, rd);
        check("t7 status after reset", rd, 64'h0);
        csr_read(3'd4, rd);
        check("t7 result after reset", rd, 64'h0);

        // Random jobs, leftover words carried between jobs
        for (int j = 0; j < 5; j++) begin
            n = $urandom_range(1, 6);
            extra = $urandom_range(0, 2);
            for (int i = 0; i < n + extra; i++) push({$urandom, $urandom});
            start_job(n, "rand");
            finish_job(n, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
